aes_inv_standard_round: RTL and testbench

AES_INV_STANDARD_ROUND -- requirements
Module: aes_inv_standard_round

---
 rtl/aes_pkg.sv | 44 ++++
 rtl/inv_sub_bytes.sv | 17 +
 rtl/aes_inv_standard_round.sv | 112 +++++++++++
 tb/tb_aes_inv_standard_round.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES decryption types, inverse S-box table and GF(2^8) arithmetic.
// Pure declarations: no timing, no flow control.
package aes_pkg;

    typedef logic [3:0][3:0][7:0] aes_state_t;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ p;
            end
            p = xtime(p);
        end
        return acc;
    endfunction

endpackage

// File: rtl/inv_sub_bytes.sv
// Four parallel inverse S-box lookups on one state row.
// Purely combinational: zero latency, no flow control.
module inv_sub_bytes
    import aes_pkg::*;
(
    input  logic [3:0][7:0] row_in,
    output logic [3:0][7:0] row_out
);

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_byte
            assign row_out[i] = INV_SBOX[row_in[i]];
        end
    endgenerate

endmodule

// File: rtl/aes_inv_standard_round.sv
// One AES inverse round (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns), 3-stage pipeline.
// Latency 3 enabled edges, one operand per enabled cycle; en=0 stalls every stage in place.
module aes_inv_standard_round
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       in_valid,
    input  aes_state_t state,
    input  aes_state_t key,
    input  logic       last_round,
    output logic       out_valid,
    output aes_state_t new_state,
    output logic       busy
);

    aes_state_t shifted;
    aes_state_t subbed;
    aes_state_t ark;
    aes_state_t mixed;
    aes_state_t round_res;

    logic       s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d, s3_vld_q, s3_vld_d;
    logic       s1_last_q, s1_last_d, s2_last_q, s2_last_d;
    aes_state_t s1_dat_q, s1_dat_d, s2_dat_q, s2_dat_d, s3_dat_q, s3_dat_d;
    aes_state_t s1_key_q, s1_key_d, s2_key_q, s2_key_d;

    genvar r, c;
    generate
        for (r = 0; r < 4; r++) begin : g_row
            for (c = 0; c < 4; c++) begin : g_col
                // Row r rotates right by r positions.
                assign shifted[r][c] = state[r][(c + 4 - r) % 4];
                assign mixed[r][c]   = gf_mul(ark[r][c],           8'h0e)
                                     ^ gf_mul(ark[(r + 1) % 4][c], 8'h0b)
                                     ^ gf_mul(ark[(r + 2) % 4][c], 8'h0d)
                                     ^ gf_mul(ark[(r + 3) % 4][c], 8'h09);
            end
            inv_sub_bytes u_inv_sub_bytes (
                .row_in  (shifted[r]),
                .row_out (subbed[r])
            );
        end
    endgenerate

    assign ark       = s2_dat_q ^ s2_key_q;
    assign round_res = s2_last_q ? ark : mixed;

    always_comb begin
        s1_vld_d  = s1_vld_q;
        s2_vld_d  = s2_vld_q;
        s3_vld_d  = s3_vld_q;
        s1_dat_d  = s1_dat_q;
        s1_key_d  = s1_key_q;
        s1_last_d = s1_last_q;
        s2_dat_d  = s2_dat_q;
        s2_key_d  = s2_key_q;
        s2_last_d = s2_last_q;
        s3_dat_d  = s3_dat_q;
        if (en) begin
            s1_vld_d = in_valid;
            s2_vld_d = s1_vld_q;
            s3_vld_d = s2_vld_q;
            // Bubbles advance the valid bits but leave stage data untouched.
            if (in_valid) begin
                s1_dat_d  = subbed;
                s1_key_d  = key;
                s1_last_d = last_round;
            end
            if (s1_vld_q) begin
                s2_dat_d  = s1_dat_q;
                s2_key_d  = s1_key_q;
                s2_last_d = s1_last_q;
            end
            if (s2_vld_q) begin
                s3_dat_d = round_res;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            s3_vld_q  <= 1'b0;
            s1_dat_q  <= '0;
            s1_key_q  <= '0;
            s1_last_q <= 1'b0;
            s2_dat_q  <= '0;
            s2_key_q  <= '0;
            s2_last_q <= 1'b0;
            s3_dat_q  <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s2_vld_q  <= s2_vld_d;
            s3_vld_q  <= s3_vld_d;
            s1_dat_q  <= s1_dat_d;
            s1_key_q  <= s1_key_d;
            s1_last_q <= s1_last_d;
            s2_dat_q  <= s2_dat_d;
            s2_key_q  <= s2_key_d;
            s2_last_q <= s2_last_d;
            s3_dat_q  <= s3_dat_d;
        end
    end

    assign out_valid = s3_vld_q;
    assign new_state = s3_dat_q;
    assign busy      = s1_vld_q | s2_vld_q | s3_vld_q;

endmodule

// File: tb/tb_aes_inv_standard_round.sv
// Self-checking bench for aes_inv_standard_round: directed table, hand sequences, random stream.
// Reference model derives the inverse S-box from GF(2^8) inversion plus the affine map.
module tb_aes_inv_standard_round;

    typedef logic [3:0][3:0][7:0] st_t;

    typedef struct {
        st_t  st;
        st_t  k;
        logic last;
        st_t  exp;
    } vec_t;

    logic clk;
    logic rst;
    logic en;
    logic in_valid;
    st_t  state;
    st_t  key;
    logic last_round;
    logic out_valid;
    st_t  new_state;
    logic busy;

    aes_inv_standard_round dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .in_valid   (in_valid),
        .state      (state),
        .key        (key),
        .last_round (last_round),
        .out_valid  (out_valid),
        .new_state  (new_state),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_bad = 0;
    int   en_cnt = 0;
    st_t  pend_res [$];
    int   pend_due [$];
    st_t  last_res;
    logic [7:0] m_inv_sbox [256];

    // Carry-less product followed by reduction modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ ({8'h00, a} << i);
        end
        for (int i = 15; i >= 8; i--) begin
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        end
        return p[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            m_inv_sbox[s] = 8'(x);
        end
    endtask

    function automatic st_t ref_round(input st_t s, input st_t k, input logic last);
        logic [7:0] a [4][4];
        logic [7:0] coef [4];
        logic [1:0] rr, cc, src, ci;
        st_t res;
        coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                rr = 2'(r);
                cc = 2'(c);
                src = cc - rr;
                a[r][c] = m_inv_sbox[s[rr][src]] ^ k[rr][cc];
            end
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                rr = 2'(r);
                cc = 2'(c);
                if (last) begin
                    res[rr][cc] = a[r][c];
                end else begin
                    res[rr][cc] = 8'h00;
                    for (int kk = 0; kk < 4; kk++) begin
                        ci = 2'(kk) - rr;
                        res[rr][cc] = res[rr][cc] ^ m_mul(coef[ci], a[kk][c]);
                    end
                end
            end
        end
        return res;
    endfunction

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    task automatic chk_st(input string nm, input st_t act, input st_t exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, check all outputs 1 time unit after the edge.
    task automatic step(input logic e, input logic v, input st_t s, input st_t k, input logic l);
        logic exp_v;
        en = e;
        in_valid = v;
        state = s;
        key = k;
        last_round = l;
        @(posedge clk);
        if (e) begin
            en_cnt++;
            if (v) begin
                pend_res.push_back(ref_round(s, k, l));
                pend_due.push_back(en_cnt + 2);
            end
        end
        #1;
        while (pend_due.size() > 0 && pend_due[0] < en_cnt) begin
            void'(pend_due.pop_front());
            void'(pend_res.pop_front());
        end
        exp_v = (pend_due.size() > 0) && (pend_due[0] == en_cnt);
        if (exp_v) last_res = pend_res[0];
        chk_bit("out_valid", out_valid, exp_v);
        chk_bit("busy", busy, pend_due.size() > 0);
        chk_st("new_state", new_state, last_res);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, '0, '0, 1'b0);
    endtask

    function automatic st_t rnd_st();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    vec_t vecs [4];
    st_t  s63;
    st_t  tmp;

    initial begin
        build_sbox();
        last_res = '0;
        s63 = {16{8'h63}};
        en = 1'b0;
        in_valid = 1'b0;
        state = '0;
        key = '0;
        last_round = 1'b0;
        rst = 1'b0;

        #2;
        chk_bit("rst_out_valid", out_valid, 1'b0);
        chk_bit("rst_busy", busy, 1'b0);
        chk_st("rst_new_state", new_state, '0);
        repeat (2) @(posedge clk);
        #5 rst = 1'b1;

        vecs[0] = '{st: s63, k: '0, last: 1'b0, exp: '0};
        vecs[1] = '{st: '0, k: {16{8'hff}}, last: 1'b0, exp: {16{8'had}}};
        tmp = s63;
        tmp[1][0] = 8'h63; tmp[1][1] = 8'h7c; tmp[1][2] = 8'h77; tmp[1][3] = 8'h7b;
        vecs[2].st = tmp; vecs[2].k = '0; vecs[2].last = 1'b1;
        tmp = '0;
        tmp[1][0] = 8'h03; tmp[1][1] = 8'h00; tmp[1][2] = 8'h01; tmp[1][3] = 8'h02;
        vecs[2].exp = tmp;
        vecs[3] = '{st: s63, k: {16{8'h5a}}, last: 1'b1, exp: {16{8'h5a}}};

        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, vecs[i].st, vecs[i].k, vecs[i].last);
            idle();
            idle();
            chk_bit("dir_out_valid", out_valid, 1'b1);
            chk_st("dir_new_state", new_state, vecs[i].exp);
            idle();
            chk_bit("dir_one_cycle", out_valid, 1'b0);
        end

        // Back-to-back operands with different keys.
        step(1'b1, 1'b1, s63, '0, 1'b0);
        step(1'b1, 1'b1, s63, {16{8'h01}}, 1'b0);
        idle();
        chk_st("b2b_first", new_state, '0);
        idle();
        chk_bit("b2b_second_vld", out_valid, 1'b1);
        chk_st("b2b_second", new_state, {16{8'h01}});
        idle();

        // Five-cycle freeze with two operands in flight.
        step(1'b1, 1'b1, s63, {16{8'h02}}, 1'b0);
        step(1'b1, 1'b1, s63, {16{8'h03}}, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, rnd_st(), rnd_st(), 1'b0);
        chk_bit("freeze_no_out", out_valid, 1'b0);
        chk_bit("freeze_busy", busy, 1'b1);
        idle();
        chk_bit("thaw_a_vld", out_valid, 1'b1);
        chk_st("thaw_a", new_state, {16{8'h02}});
        idle();
        chk_st("thaw_b", new_state, {16{8'h03}});
        idle();

        // Asynchronous reset with three operands in flight.
        step(1'b1, 1'b1, s63, {16{8'h11}}, 1'b0);
        step(1'b1, 1'b1, s63, {16{8'h22}}, 1'b0);
        step(1'b1, 1'b1, s63, {16{8'h33}}, 1'b0);
        #3 rst = 1'b0;
        #1;
        chk_bit("arst_out_valid", out_valid, 1'b0);
        chk_bit("arst_busy", busy, 1'b0);
        chk_st("arst_new_state", new_state, '0);
        pend_res.delete();
        pend_due.delete();
        last_res = '0;
        en = 1'b1;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #4 rst = 1'b0;
        #1 rst = 1'b1;
        for (int i = 0; i < 4; i++) idle();
        step(1'b1, 1'b1, s63, {16{8'h44}}, 1'b0);
        idle();
        idle();
        chk_st("post_rst_first", new_state, {16{8'h44}});

        // Randomized stream with random stalls and bubbles.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 rnd_st(), rnd_st(), ($urandom_range(0, 3) == 0));
        end
        for (int i = 0; i < 4; i++) idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
